mode_led: RTL
=============

MODE_LED -- requirements
Module: mode_led

Interface
REQ-001 Parameter ON_CYC, default 2500000, clocks LED is lit per pulse; legal range >= 1.
REQ-002 Parameter OFF_CYC, default 2500000, clocks LED is dark between pulses; legal range >= 1.
REQ-003 Parameter GAP_CYC, default 10000000, extra dark clocks after the last pulse of a frame; legal range >= 1.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 setting  input  2  current assist/mode setting from the push-button block, synchronous to clk, value 0..3.
REQ-007 led  output  1  user indicator, high = lit, driven directly from a flop.
REQ-008 frame_done  output  1  one-cycle pulse marking the end of a complete blink frame.

Function
REQ-009 The block SHALL blink led N times per frame, then stay dark for the gap, repeating indefinitely, where N = setting.
REQ-010 The block SHALL hold a registered copy setting_q and treat setting != setting_q at a clock edge as a change event.
REQ-011 A change event SHALL update setting_q, reload the pulse counter with setting, clear the cycle counter, and enter ON (setting != 0) or IDLE (setting == 0) on that same edge.
REQ-012 The FSM SHALL have states IDLE, ON, OFF and GAP, with led = 1 only in ON.
REQ-013 IDLE SHALL hold led = 0 and frame_done = 0 until a change event.
REQ-014 ON SHALL last exactly ON_CYC cycles, then go to OFF.
REQ-015 OFF SHALL last exactly OFF_CYC cycles, then decrement the pulse counter.
REQ-016 After OFF, the FSM SHALL go to ON if pulses remain, else to GAP.
REQ-017 GAP SHALL last exactly GAP_CYC cycles, then reload the pulse counter from setting_q and go to ON.
REQ-018 frame_done SHALL be high for exactly one cycle: the last cycle of GAP.
REQ-019 Period per pulse SHALL be ON_CYC+OFF_CYC; frame length SHALL be N*(ON_CYC+OFF_CYC)+GAP_CYC.
REQ-020 The cycle counter width SHALL be $clog2 of the maximum of ON_CYC, OFF_CYC and GAP_CYC, plus 1; it SHALL never wrap.
REQ-021 A change event SHALL take priority over every phase expiry on the same edge; in that case frame_done stays 0.
REQ-022 A setting glitch that reverts before being sampled at a clock edge SHALL have no effect.
REQ-023 Writing the same setting value again SHALL NOT restart the frame.

Reset
REQ-024 While rst_n = 0, the block SHALL hold state = IDLE, setting_q = 0, all counters = 0, led = 0 and frame_done = 0.
REQ-025 Reset assertion SHALL force led low immediately, independent of clk, including mid-pulse.
REQ-026 After reset release, a nonzero setting SHALL be seen as a change on the first clock edge, starting a frame.

Structure
REQ-027 Package mode_led_pkg SHALL hold the state enum type and the default ON/OFF/GAP constants.
REQ-028 One sub-module, phase_timer, SHALL be used: a load/count-down cycle timer with a one-cycle expire output.
REQ-029 The FSM, pulse counter and setting_q SHALL reside in mode_led.

Verification (ON_CYC=4, OFF_CYC=3, GAP_CYC=10; cycle 0 = first edge after reset release)
REQ-030 setting=2 from reset -> led high in cycles 1-4 and 8-11, low in cycles 5-7 and 12-24; frame_done high in cycle 24 only; led high again at cycle 25.
REQ-031 setting=3 held -> 3 pulses per frame; frame_done pulses repeat every 31 cycles.
REQ-032 setting changes 3->1 during the second ON -> restart on the next edge with 4 lit cycles, then 3+10 dark cycles; no frame_done until the new frame completes.
REQ-033 setting=0 -> led and frame_done stay 0 for 200 cycles; then setting=1 -> led high on the next cycle.
REQ-034 rst_n pulsed low mid-ON -> led goes 0 without a clock edge; after release, the frame restarts per REQ-026.
REQ-035 Change event coincident with the last GAP cycle -> no frame_done pulse; new frame starts per REQ-011.

Source files
------------

// File: rtl/mode_led_pkg.sv
// Shared types and default timing constants for the mode indicator LED.
package mode_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int unsigned DEF_ON_CYC  = 2500000;
    localparam int unsigned DEF_OFF_CYC = 2500000;
    localparam int unsigned DEF_GAP_CYC = 10000000;

    // Largest of three phase lengths; sizes the shared cycle counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mode_led_phase_timer.sv
// Load/count-down cycle timer; expire flags the final cycle of a loaded phase.
module phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         run_i,
    output logic         expire_c_o
);

    logic [W-1:0] cnt_q;

    // Load takes precedence; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Expiry only matters while a timed phase is active.
    assign expire_c_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/mode_led.sv
// Blinks the LED N times per frame (N = setting), then a dark gap, forever.
module mode_led
    import mode_led_pkg::*;
#(
    parameter int unsigned ON_CYC  = DEF_ON_CYC,
    parameter int unsigned OFF_CYC = DEF_OFF_CYC,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] setting,
    output logic       led,
    output logic       frame_done
);

    localparam int unsigned MAX_CYC = max3(ON_CYC, OFF_CYC, GAP_CYC);
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);

    state_e        state_q, state_d;
    logic [1:0]    setting_q, setting_d;
    logic [1:0]    pulse_q, pulse_d;
    logic          led_q, led_d;
    logic          frame_done_q, frame_done_d;
    logic          tmr_load;
    logic [CW-1:0] tmr_load_val;
    logic          tmr_run;
    logic          tmr_expire;
    logic          change;

    phase_timer #(
        .W(CW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .run_i      (tmr_run),
        .expire_c_o (tmr_expire)
    );

    assign change  = (setting != setting_q);
    assign tmr_run = (state_q != ST_IDLE);

    // State, setting copy, pulse counter and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            setting_q    <= 2'd0;
            pulse_q      <= 2'd0;
            led_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            setting_q    <= setting_d;
            pulse_q      <= pulse_d;
            led_q        <= led_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Phase sequencing; a setting change overrides any expiry on the same edge.
    always_comb begin
        state_d      = state_q;
        setting_d    = setting_q;
        pulse_d      = pulse_q;
        led_d        = (state_q == ST_ON);
        frame_done_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            ST_ON: begin
                if (tmr_expire) begin
                    state_d      = ST_OFF;
                    tmr_load     = 1'b1;
                    tmr_load_val = OFF_LOAD;
                end
            end
            ST_OFF: begin
                if (tmr_expire) begin
                    pulse_d  = pulse_q - 2'd1;
                    tmr_load = 1'b1;
                    if (pulse_q > 2'd1) begin
                        state_d      = ST_ON;
                        tmr_load_val = ON_LOAD;
                    end else begin
                        state_d      = ST_GAP;
                        tmr_load_val = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_d      = ST_ON;
                    pulse_d      = setting_q;
                    frame_done_d = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = ON_LOAD;
                end
            end
            default: begin
            end
        endcase

        if (change) begin
            setting_d    = setting;
            pulse_d      = setting;
            frame_done_d = 1'b0;
            tmr_load     = 1'b1;
            if (setting != 2'd0) begin
                state_d      = ST_ON;
                tmr_load_val = ON_LOAD;
            end else begin
                state_d      = ST_IDLE;
                tmr_load_val = '0;
            end
        end
    end

    assign led        = led_q;
    assign frame_done = frame_done_q;

endmodule
